// File: rtl/mem_lsu.sv
// mem_lsu: load/store sequencer between the CPU datapath and a 256 x 8-bit
// synchronous memory. A byte/half/word request becomes 1/2/4 consecutive
// single-byte accesses. Read data is assembled little-endian and one response
// pulse is returned per request.
// Optional feature: define MEM_LSU_ALIGN_CHECK_EN to reject misaligned requests
// with resp_err instead of performing them byte-by-byte.
module mem_lsu #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t              state, state_nxt;
    logic                accept;
    logic                last_byte;
    logic                align_err;
    logic                err_q;

    // Request captured on the accept edge
    logic                wr_q;
    logic [1:0]          last_q;
    logic [ADDR_W-1:0]   base_q;
    logic [DATA_W-1:0]   wdata_q;

    // Index of the byte currently presented on mem_addr
    logic [1:0]          k_q;
    logic [1:0]          k_nxt;

    // Read capture stage: one cycle behind the address stage
    logic                vld_p1;
    logic [1:0]          idx_p1;
    logic [DATA_W-1:0]   asm_q;
    logic [DATA_W-1:0]   asm_merged;

    // Index of the final byte: size 3 is handled as a word
    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

`ifdef MEM_LSU_ALIGN_CHECK_EN
    // Half needs addr[0]=0, word needs addr[1:0]=0, size 3 is never legal
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return a != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    assign align_err = misaligned(req_size, req_addr[1:0]);
`else
    assign align_err = 1'b0;
`endif

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = err_q;
    assign last_byte  = (k_q == last_q);
    assign k_nxt      = k_q + 2'd1;

    // Next-state decode and accept strobe
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = align_err ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (last_byte) begin
                    state_nxt = wr_q ? RESP : DRAIN;
                end
            end
            DRAIN:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory interface: load byte 0 on accept, then step through the bytes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept && !align_err) begin
            mem_we    <= req_write;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata[7:0];
        end else if (state == ISSUE) begin
            if (last_byte) begin
                mem_we <= 1'b0;
            end else begin
                mem_addr  <= base_q + ADDR_W'(k_nxt);
                mem_wdata <= wdata_q[{k_nxt, 3'b000} +: 8];
            end
        end
    end

    // Request latch, byte counter and read assembly (data path, no reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= req_write;
            last_q  <= last_index(req_size);
            base_q  <= req_addr;
            wdata_q <= req_wdata;
            k_q     <= 2'd0;
            asm_q   <= '0;
        end else begin
            if (state == ISSUE && !last_byte) begin
                k_q <= k_nxt;
            end
            asm_q <= asm_merged;
        end
        idx_p1 <= k_q;
    end

    // Capture-valid tracks a load address presented in the previous cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= (state == ISSUE) && !wr_q;
        end
    end

    // Merge the byte returned this cycle into the assembly value
    always_comb begin
        asm_merged = asm_q;
        if (vld_p1) begin
            asm_merged[{idx_p1, 3'b000} +: 8] = mem_rdata;
        end
    end

    // Response data and error, held until the next response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_rdata <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                err_q <= align_err;
            end
            if (accept && align_err) begin
                resp_rdata <= '0;
            end else if (state == ISSUE && last_byte && wr_q) begin
                resp_rdata <= '0;
            end else if (state == DRAIN) begin
                resp_rdata <= asm_merged;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed, table-driven bench for mem_lsu with a behavioural
// 256 x 8 synchronous memory (write and registered read on the rising edge).
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_size;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;

    logic [7:0]  mem [0:255];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] prev_rd  = '0;
    logic [7:0]  tr_addr [0:7];
    logic [7:0]  tr_wd   [0:7];

    mem_lsu #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem_rdata = 8'h00;
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Presents one request in cycle 0, then scrambles the request inputs and
    // watches cycles 1..20 for the response, counting mem_we cycles.
    task automatic run_req(input string tag, input logic w, input logic [1:0] sz,
                           input logic [7:0] a, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd,
                           output logic er, output int wecnt);
        @(negedge clk);
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        check({tag, "_held"}, resp_rdata, prev_rd);
        req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_write = ~w; req_size = ~sz; req_addr = 8'h5A; req_wdata = 32'hCAFEF00D;
        lat = -1; rd = '0; er = 1'b0; wecnt = 0;
        for (int c = 1; c <= 20; c++) begin
            if (mem_we) begin
                if (wecnt < 8) begin
                    tr_addr[wecnt] = mem_addr;
                    tr_wd[wecnt]   = mem_wdata;
                end
                wecnt++;
            end
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                break;
            end
            @(negedge clk);
        end
        prev_rd = rd;
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic        exp_err;
        int          exp_we;
    } vec_t;

    vec_t vt [0:9];

    initial begin : main
        int          lat, wecnt;
        logic [31:0] rd;
        logic        er;
        int          acc [0:3];
        int          rsp [0:3];
        int          nacc, nrsp;
        logic        saw_resp;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_size = 2'd0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_ready",  {31'b0, req_ready},  32'd1);
        check("rst_rvalid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata",  resp_rdata,          32'd0);
        check("rst_err",    {31'b0, resp_err},   32'd0);
        check("rst_we",     {31'b0, mem_we},     32'd0);
        check("rst_addr",   {24'b0, mem_addr},   32'd0);
        check("rst_wdata",  {24'b0, mem_wdata},  32'd0);

        // Word store with full address/data trace
        run_req("st_w", 1'b1, 2'd2, 8'h10, 32'h11223344, lat, rd, er, wecnt);
        check("st_w_lat", 32'(lat), 32'd5);
        check("st_w_err", {31'b0, er}, 32'd0);
        check("st_w_rd",  rd, 32'd0);
        check("st_w_we",  32'(wecnt), 32'd4);
        check("st_w_a0",  {24'b0, tr_addr[0]}, 32'h10);
        check("st_w_a3",  {24'b0, tr_addr[3]}, 32'h13);
        check("st_w_d0",  {24'b0, tr_wd[0]}, 32'h44);
        check("st_w_d1",  {24'b0, tr_wd[1]}, 32'h33);
        check("st_w_d2",  {24'b0, tr_wd[2]}, 32'h22);
        check("st_w_d3",  {24'b0, tr_wd[3]}, 32'h11);

        //          w     sz    addr   wdata          exp_rd         lat err we
        vt[0] = '{1'b0, 2'd2, 8'h10, 32'h0,         32'h11223344,  6, 1'b0, 0};
        vt[1] = '{1'b1, 2'd0, 8'h13, 32'h000000A5,  32'h0,         2, 1'b0, 1};
        vt[2] = '{1'b0, 2'd1, 8'h12, 32'h0,         32'h0000A522,  4, 1'b0, 0};
        vt[3] = '{1'b0, 2'd0, 8'h11, 32'h0,         32'h00000033,  3, 1'b0, 0};
        vt[4] = '{1'b0, 2'd0, 8'h80, 32'h0,         32'h00000000,  3, 1'b0, 0};
`ifdef MEM_LSU_ALIGN_CHECK_EN
        vt[5] = '{1'b1, 2'd1, 8'hFF, 32'h0000BEEF,  32'h0,         1, 1'b1, 0};
        vt[6] = '{1'b0, 2'd1, 8'hFF, 32'h0,         32'h0,         1, 1'b1, 0};
        vt[7] = '{1'b0, 2'd2, 8'hFE, 32'h0,         32'h0,         1, 1'b1, 0};
        vt[8] = '{1'b0, 2'd3, 8'h10, 32'h0,         32'h0,         1, 1'b1, 0};
        vt[9] = '{1'b0, 2'd0, 8'hFF, 32'h0,         32'h00000000,  3, 1'b0, 0};
`else
        vt[5] = '{1'b1, 2'd1, 8'hFF, 32'h0000BEEF,  32'h0,         3, 1'b0, 2};
        vt[6] = '{1'b0, 2'd1, 8'hFF, 32'h0,         32'h0000BEEF,  4, 1'b0, 0};
        vt[7] = '{1'b0, 2'd2, 8'hFE, 32'h0,         32'h00BEEF00,  6, 1'b0, 0};
        vt[8] = '{1'b0, 2'd3, 8'h10, 32'h0,         32'hA5223344,  6, 1'b0, 0};
        vt[9] = '{1'b0, 2'd0, 8'hFF, 32'h0,         32'h000000EF,  3, 1'b0, 0};
`endif

        for (int i = 0; i < 10; i++) begin
            run_req($sformatf("v%0d", i), vt[i].w, vt[i].sz, vt[i].addr, vt[i].wd,
                    lat, rd, er, wecnt);
            check($sformatf("v%0d_lat", i),   32'(lat),     32'(vt[i].exp_lat));
            check($sformatf("v%0d_rdata", i), rd,           vt[i].exp_rd);
            check($sformatf("v%0d_err", i),   {31'b0, er},  {31'b0, vt[i].exp_err});
            check($sformatf("v%0d_we", i),    32'(wecnt),   32'(vt[i].exp_we));
            for (int j = 0; j < vt[i].exp_we && j < wecnt && j < 8; j++) begin
                check($sformatf("v%0d_addr%0d", i, j), {24'b0, tr_addr[j]},
                      {24'b0, vt[i].addr + 8'(j)});
                check($sformatf("v%0d_wd%0d", i, j), {24'b0, tr_wd[j]},
                      {24'b0, vt[i].wd[8*j +: 8]});
            end
        end

        // Wrapped half store landed in memory
`ifdef MEM_LSU_ALIGN_CHECK_EN
        check("mem_ff", {24'b0, mem[8'hFF]}, 32'h00);
        check("mem_00", {24'b0, mem[8'h00]}, 32'h00);
`else
        check("mem_ff", {24'b0, mem[8'hFF]}, 32'hEF);
        check("mem_00", {24'b0, mem[8'h00]}, 32'hBE);
`endif

        // Back-to-back word loads with req_valid held high
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 8'h10; req_wdata = '0;
        nacc = 0; nrsp = 0;
        for (int c = 0; c <= 20; c++) begin
            if (nacc >= 2) req_valid = 1'b0;
            if (resp_valid && nrsp < 4) begin
                rsp[nrsp] = c;
                check($sformatf("b2b_rdata%0d", nrsp), resp_rdata, 32'hA5223344);
                nrsp++;
            end
            if (req_valid && req_ready && nacc < 4) begin
                acc[nacc] = c;
                nacc++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        prev_rd = 32'hA5223344;
        check("b2b_nrsp", 32'(nrsp), 32'd2);
        check("b2b_nacc", 32'(nacc), 32'd2);
        if (nrsp == 2 && nacc == 2) begin
            check("b2b_first", 32'(rsp[0]), 32'd6);
            check("b2b_gap",   32'(rsp[1] - rsp[0]), 32'd7);
            check("b2b_acc2",  32'(acc[1]), 32'(rsp[0] + 1));
        end

        // Word store aborted by reset on the edge ending cycle 2
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 8'h20; req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_we_c2", {31'b0, mem_we}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_ready", {31'b0, req_ready},  32'd1);
        check("abort_we",    {31'b0, mem_we},     32'd0);
        check("abort_addr",  {24'b0, mem_addr},   32'd0);
        check("abort_wdata", {24'b0, mem_wdata},  32'd0);
        check("abort_rdata", resp_rdata,          32'd0);
        saw_resp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (resp_valid) saw_resp = 1'b1;
            @(negedge clk);
        end
        check("abort_noresp", {31'b0, saw_resp}, 32'd0);
        check("abort_m20", {24'b0, mem[8'h20]}, 32'hEF);
        check("abort_m21", {24'b0, mem[8'h21]}, 32'hBE);
        check("abort_m22", {24'b0, mem[8'h22]}, 32'h00);
        check("abort_m23", {24'b0, mem[8'h23]}, 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store sequencer between the CPU datapath and the 256 × 8-bit synchronous instruction/data memory. It accepts one byte, halfword or word load/store request at a time and turns it into 1, 2 or 4 consecutive single-byte memory accesses. It runs reads as a pipeline against the memory's one-cycle registered read, assembles the read data little-endian, and returns one response pulse per request.

## Interface
- ADDR_W, 8, memory address width; byte addresses wrap modulo 2^ADDR_W.
- DATA_W, 32, CPU-side data width; fixed at 4 bytes.

Ports:
- clk  in  1  system clock; all logic updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_addr  in  ADDR_W  byte base address.
- req_wdata  in  DATA_W  store data; byte k = req_wdata[8k+7:8k].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  load data, zero-extended; 0 for stores; held until the next resp_valid.
- resp_err  out  1  alignment error; qualified by resp_valid.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_wdata  out  8  memory write byte, registered.
- mem_rdata  in  8  memory read byte; valid the cycle after mem_addr was presented.

## Operation
- States: IDLE, ISSUE, DRAIN, RESP.
- IDLE:
  - On accept, latch write, size, addr and wdata.
  - Set N = 1/2/4 for size 0/1/2. Size 3 is treated as 4.
  - Load mem_addr = addr, mem_we = write, mem_wdata = wdata[7:0], k = 0.
  - Go to ISSUE.
- ISSUE:
  - Each cycle presents byte k at mem_addr = (base + k) mod 256.
  - On each edge, k increments and the next byte's addr/wdata are loaded.
  - After byte N-1, mem_we is cleared. A store goes to RESP; a load goes to DRAIN.
- Load capture:
  - In the cycle after byte k is presented, mem_rdata is written into bits [8k+7:8k] of the assembly register.
  - Bytes not captured (byte and half sizes) are 0.
  - DRAIN captures the final byte.
- RESP: resp_valid = 1 for one cycle, with resp_rdata and resp_err stable; then return to IDLE.
- Request inputs are ignored except on the accept edge.
- req_ready is 0 in ISSUE, DRAIN and RESP. There is no request overlap.
- Address wrap: base 0xFF with size word accesses 0xFF, 0x00, 0x01, 0x02.
- Reset mid-operation: the edge with rst_n = 0 forces IDLE and all outputs to reset values.
  - Bytes already written remain in memory.
  - No resp_valid is issued for the aborted request.

## Timing
- Reset values: req_ready = 1 (IDLE), resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Accept edge = edge 0. Cycle c is the cycle following edge c-1.
- Store: mem_we is high in cycles 1..N, and the memory writes at the end of each of those cycles. resp_valid is in cycle N+1 (byte 2, half 3, word 5).
- Load: addresses in cycles 1..N, captures at the end of cycles 2..N+1, resp_valid in cycle N+2 (byte 3, half 4, word 6).
- Next accept is possible in the cycle after RESP. Back-to-back word loads take 7 cycles each.

## Configuration
- MEM_LSU_ALIGN_CHECK_EN defined:
  - An accepted request is misaligned if size 1 with addr[0] = 1, size 2 with addr[1:0] ≠ 0, or size 3.
  - A misaligned request skips ISSUE and DRAIN and goes straight to RESP: resp_valid in cycle 1, resp_err = 1, resp_rdata = 0.
  - No memory access and no mem_we pulse occur.
- MEM_LSU_ALIGN_CHECK_EN undefined:
  - resp_err is tied to 0.
  - Every request is performed byte-by-byte as above, including misaligned requests and wrap-around; size 3 is treated as a word.

## Test plan
- Word store 0x11223344 at 0x10 -> mem_we high in cycles 1–4, mem_addr 0x10..0x13, mem_wdata 0x44, 0x33, 0x22, 0x11; resp_valid in cycle 5, resp_err = 0.
- Word load at 0x10 after the above -> resp_valid in cycle 6 with resp_rdata = 0x11223344; mem_we stays 0 throughout.
- Byte store 0xA5 at 0x13, then half load at 0x12 -> resp_rdata = 0x0000A522, resp_valid in cycle 4.
- Half store 0xBEEF at 0xFF, macro undefined -> memory[0xFF] = 0xEF and memory[0x00] = 0xBE; a half load at 0xFF returns 0x0000BEEF. Macro defined -> resp_valid in cycle 1 with resp_err = 1 and no mem_we.
- Word store 0xDEADBEEF at 0x20 with rst_n low on the edge ending cycle 2 -> memory[0x20..0x21] = EF, BE and memory[0x22..0x23] unchanged; no resp_valid; req_ready = 1 the cycle after reset.
- req_valid held high for two word loads -> second accept in the cycle after the first RESP; responses are 7 cycles apart.
